bmc_burst_decoder: RTL and testbench

- Per-photodiode front-end stage, one instance per TS4231 channel, directly upstream of the receiver's LFSR/polynomial identification and timestamp logic.
- Synchronises the raw envelope and data wires and decodes the biphase-mark (BMC) light burst into a bit stream.
- Assembles the first WORD_BITS decoded bits into one parallel word, tagged with the timestamp of the burst's reference edge.
- Reports malformed bursts (glitch, orphan half-bit, too few bits) with an error pulse and code.

---
 rtl/bmc_burst_decoder.sv | 197 +++++++++++++++++++
 tb/tb_bmc_burst_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_burst_decoder.sv
// Biphase-mark light-burst decoder for one TS4231 channel: synchronises E/D,
// decodes the BMC bit stream, assembles the first WORD_BITS bits with a timestamp.
module bmc_burst_decoder #(
    parameter int unsigned HALF_MIN  = 4,
    parameter int unsigned THRESH    = 12,
    parameter int unsigned SLOW_MAX  = 24,
    parameter int unsigned WORD_BITS = 17,
    parameter int unsigned TS_W      = 24
) (
    input  logic                 clk_25MHz,
    input  logic                 reset_n,
    input  logic                 envelop_wire,
    input  logic                 data_wire,
    input  logic [TS_W-1:0]      ts_in,
    output logic                 bit_valid,
    output logic                 bit_value,
    output logic                 word_valid,
    output logic [WORD_BITS-1:0] word,
    output logic [TS_W-1:0]      word_ts,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IVL_W = CNT_W + 1;
    localparam int unsigned BC_W  = $clog2(WORD_BITS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [1:0] ERR_GLITCH = 2'd1;
    localparam logic [1:0] ERR_ORPHAN = 2'd2;
    localparam logic [1:0] ERR_SHORT  = 2'd3;

    // Reset asserts asynchronously, releases two clocks later in this domain
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];

    logic [2:0]           data_s;
    logic [1:0]           env_s;
    logic [1:0]           state,        state_nxt;
    logic [CNT_W-1:0]     cnt,          cnt_nxt;
    logic                 half_pending, half_nxt;
    logic [BC_W-1:0]      bit_count,    bc_nxt;
    logic [WORD_BITS-1:0] shreg,        shreg_nxt;
    logic [TS_W-1:0]      ts_ref,       ts_ref_nxt;
    logic                 bit_valid_nxt, bit_value_nxt, word_valid_nxt, err_nxt;
    logic [WORD_BITS-1:0] word_nxt;
    logic [TS_W-1:0]      word_ts_nxt;
    logic [1:0]           err_code_nxt;
    logic                 emit, emit_val, abort;

    logic             edge_c, env_high_c, timeout_c;
    logic [IVL_W-1:0] ivl_c;

    // Stage 2 vs its delayed copy; envelope uses the same depth so timing lines up
    assign edge_c     = data_s[2] ^ data_s[1];
    assign env_high_c = env_s[1];
    assign ivl_c      = IVL_W'(cnt) + IVL_W'(1);
    assign timeout_c  = !edge_c && (ivl_c >= IVL_W'(SLOW_MAX));

    always_ff @(posedge clk_25MHz or negedge rst_n_int) begin
        if (!rst_n_int) begin
            data_s       <= '1;
            env_s        <= '1;
            state        <= ST_IDLE;
            cnt          <= '0;
            half_pending <= 1'b0;
            bit_count    <= '0;
            shreg        <= '0;
            ts_ref       <= '0;
            bit_valid    <= 1'b0;
            bit_value    <= 1'b0;
            word_valid   <= 1'b0;
            word         <= '0;
            word_ts      <= '0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            data_s       <= {data_s[1:0], data_wire};
            env_s        <= {env_s[0], envelop_wire};
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            half_pending <= half_nxt;
            bit_count    <= bc_nxt;
            shreg        <= shreg_nxt;
            ts_ref       <= ts_ref_nxt;
            bit_valid    <= bit_valid_nxt;
            bit_value    <= bit_value_nxt;
            word_valid   <= word_valid_nxt;
            word         <= word_nxt;
            word_ts      <= word_ts_nxt;
            err          <= err_nxt;
            err_code     <= err_code_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = edge_c ? '0 : ((cnt == '1) ? cnt : cnt + CNT_W'(1));
        half_nxt       = half_pending;
        bc_nxt         = bit_count;
        shreg_nxt      = shreg;
        ts_ref_nxt     = ts_ref;
        bit_valid_nxt  = 1'b0;
        bit_value_nxt  = 1'b0;
        word_valid_nxt = 1'b0;
        word_nxt       = word;
        word_ts_nxt    = word_ts;
        err_nxt        = 1'b0;
        err_code_nxt   = err_code;
        emit           = 1'b0;
        emit_val       = 1'b0;
        abort          = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!env_high_c) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (env_high_c) begin
                    state_nxt = ST_IDLE;
                end else if (edge_c) begin
                    ts_ref_nxt = ts_in;
                    bc_nxt     = '0;
                    half_nxt   = 1'b0;
                    state_nxt  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (edge_c) begin
                    if (ivl_c < IVL_W'(HALF_MIN)) begin
                        abort        = 1'b1;
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_GLITCH;
                    end else if (ivl_c < IVL_W'(THRESH)) begin
                        if (half_pending) begin
                            emit     = 1'b1;
                            emit_val = 1'b1;
                            half_nxt = 1'b0;
                        end else begin
                            half_nxt = 1'b1;
                        end
                    end else if (half_pending) begin
                        abort        = 1'b1;
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_ORPHAN;
                    end else begin
                        emit = 1'b1;
                    end
                end
                if (abort) state_nxt = ST_DRAIN;

                if (emit) begin
                    bit_valid_nxt = 1'b1;
                    bit_value_nxt = emit_val;
                    if (bit_count < BC_W'(WORD_BITS)) begin
                        shreg_nxt = {shreg[WORD_BITS-2:0], emit_val};
                        bc_nxt    = bit_count + BC_W'(1);
                        if (bc_nxt == BC_W'(WORD_BITS)) begin
                            word_valid_nxt = 1'b1;
                            word_nxt       = shreg_nxt;
                            word_ts_nxt    = ts_ref;
                        end
                    end
                end

                // End-of-burst check sees the edge's effect from this same cycle
                if (!abort && (env_high_c || timeout_c)) begin
                    if (half_nxt) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_ORPHAN;
                    end else if (bc_nxt < BC_W'(WORD_BITS)) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_SHORT;
                    end
                    state_nxt = env_high_c ? ST_IDLE : ST_ARMED;
                end
            end
            ST_DRAIN: begin
                if (env_high_c) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bmc_burst_decoder.sv
// Directed and randomized bench for bmc_burst_decoder; expected values come from
// the bits the bench encodes, not from decoding the line.
module tb_bmc_burst_decoder;

    localparam int unsigned HALF_MIN  = 4;
    localparam int unsigned THRESH    = 12;
    localparam int unsigned SLOW_MAX  = 24;
    localparam int unsigned WORD_BITS = 17;
    localparam int unsigned TS_W      = 24;

    logic                 clk_25MHz    = 1'b0;
    logic                 reset_n      = 1'b0;
    logic                 envelop_wire = 1'b1;
    logic                 data_wire    = 1'b1;
    logic [TS_W-1:0]      ts_in        = 24'h00F000;
    logic                 bit_valid, bit_value, word_valid, err;
    logic [WORD_BITS-1:0] word;
    logic [TS_W-1:0]      word_ts;
    logic [1:0]           err_code;

    bmc_burst_decoder #(
        .HALF_MIN(HALF_MIN), .THRESH(THRESH), .SLOW_MAX(SLOW_MAX),
        .WORD_BITS(WORD_BITS), .TS_W(TS_W)
    ) dut (
        .clk_25MHz(clk_25MHz), .reset_n(reset_n), .envelop_wire(envelop_wire),
        .data_wire(data_wire), .ts_in(ts_in), .bit_valid(bit_valid),
        .bit_value(bit_value), .word_valid(word_valid), .word(word),
        .word_ts(word_ts), .err(err), .err_code(err_code)
    );

    always #20 clk_25MHz = ~clk_25MHz;
    always @(posedge clk_25MHz) ts_in <= ts_in + 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    bit                   bit_q[$];
    logic [WORD_BITS-1:0] word_q[$];
    logic [TS_W-1:0]      wts_q[$];
    logic [1:0]           err_q[$];
    int                   wv_bits;
    logic [TS_W-1:0]      wv_ts, err_ts;

    bit              cur[$];
    logic [TS_W-1:0] ref_ts_exp, wdrive_ts, last_drive_ts, ts_a, ts_b;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk_25MHz) begin
        if (reset_n) begin
            if (bit_valid) bit_q.push_back(bit_value);
            if (word_valid) begin
                word_q.push_back(word);
                wts_q.push_back(word_ts);
                wv_bits <= bit_q.size();
                wv_ts   <= ts_in;
            end
            if (err) begin
                err_q.push_back(err_code);
                err_ts <= ts_in;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    // Wait n clocks after the previous transition, then toggle the line
    task automatic gap(input int n);
        tick(n);
        data_wire = ~data_wire;
    endtask

    task automatic clr();
        bit_q.delete(); word_q.delete(); wts_q.delete(); err_q.delete();
    endtask

    task automatic load_str(input string s);
        cur.delete();
        for (int i = 0; i < s.len(); i++) cur.push_back(s[i] == "1");
    endtask

    function automatic int jit();
        return int'($urandom_range(6)) - 3;
    endfunction

    function automatic logic [31:0] pack_cur(input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n && i < cur.size(); i++) v = (v << 1) | 32'(cur[i]);
        return v;
    endfunction

    function automatic logic [31:0] pack_obs();
        logic [31:0] v = '0;
        for (int i = 0; i < bit_q.size() && i < 32; i++) v = (v << 1) | 32'(bit_q[i]);
        return v;
    endfunction

    // BMC encoder: mode 0 nominal, 1 jittered +/-3, 2 interval boundaries
    task automatic send_burst(input int n, input int mode);
        data_wire  = ~data_wire;
        ref_ts_exp = ts_in + TS_W'(2);
        for (int i = 0; i < n; i++) begin
            if (cur[i]) begin
                gap(mode == 0 ? 8 : (mode == 1 ? 8 + jit() : int'(HALF_MIN)));
                gap(mode == 0 ? 8 : (mode == 1 ? 8 + jit() : int'(THRESH) - 1));
            end else begin
                gap(mode == 0 ? 16 : (mode == 1 ? 16 + jit() :
                    ((i % 2) == 1 ? int'(SLOW_MAX) : int'(THRESH))));
            end
            if (i == int'(WORD_BITS) - 1) wdrive_ts = ts_in;
        end
        last_drive_ts = ts_in;
    endtask

    task automatic start();
        clr();
        envelop_wire = 1'b0;
        tick(4);
    endtask

    task automatic finish_burst();
        tick(32);
        envelop_wire = 1'b1;
        tick(6);
    endtask

    task automatic check_clean(input string tag, input int n);
        chk({tag, ".nbits"}, bit_q.size(), n);
        chk({tag, ".bits"},  pack_obs(), pack_cur(n));
        chk({tag, ".nword"}, word_q.size(), 1);
        chk({tag, ".word"},  word, pack_cur(WORD_BITS));
        chk({tag, ".ts"},    word_ts, ref_ts_exp);
        chk({tag, ".wbits"}, wv_bits, WORD_BITS);
        chk({tag, ".wlat"},  wv_ts, wdrive_ts + TS_W'(3));
        chk({tag, ".nerr"},  err_q.size(), 0);
    endtask

    task automatic check_err(input string tag, input int nbits, input logic [1:0] code);
        chk({tag, ".nbits"}, bit_q.size(), nbits);
        chk({tag, ".nword"}, word_q.size(), 0);
        chk({tag, ".nerr"},  err_q.size(), 1);
        chk({tag, ".code"},  err_code, code);
    endtask

    initial begin
        tick(5);
        chk("rst.hold", {bit_valid, word_valid, err, err_code, word, word_ts}, 64'd0);
        reset_n = 1'b1;
        tick(8);
        chk("rst.idle", {bit_valid, word_valid, err, err_code, word, word_ts}, 64'd0);

        // Clean nominal burst
        load_str("01110010111101001");
        start(); send_burst(17, 0); finish_burst();
        check_clean("clean", 17);
        chk("clean.const", word, 17'h0E5E9);

        // Same burst, every interval jittered
        start(); send_burst(17, 1); finish_burst();
        check_clean("jitter", 17);
        chk("jitter.const", word, 17'h0E5E9);

        // Exact HALF_MIN / THRESH-1 / THRESH / SLOW_MAX intervals
        start(); send_burst(17, 2); finish_burst();
        check_clean("bound", 17);

        // Glitches of 2 and 3 clocks after a half interval
        for (int w = 2; w <= 3; w++) begin
            start(); send_burst(5, 0);
            gap(6); gap(w);
            gap(16); gap(8); gap(8);
            finish_burst();
            check_err($sformatf("glitch%0d", w), 5, 2'd1);
        end
        start(); send_burst(17, 0); finish_burst();
        check_clean("after_glitch", 17);
        chk("glitch.code_held", err_code, 2'd1);

        // Short burst ended by timeout
        start(); send_burst(10, 0); finish_burst();
        check_err("short", 10, 2'd3);
        chk("short.lat", err_ts, last_drive_ts + TS_W'(SLOW_MAX + 3));

        // Half then full interval
        start(); send_burst(3, 0); gap(8); gap(16); finish_burst();
        check_err("orphan", 3, 2'd2);

        // Trailing half-bit at end of a short burst outranks the short code
        start(); send_burst(10, 0); gap(8); finish_burst();
        check_err("tail_half", 10, 2'd2);

        // Two bursts within one envelope window
        start();
        load_str("01110010111101001");
        send_burst(17, 0); ts_a = ref_ts_exp;
        tick(32);
        load_str("01111000111001000");
        send_burst(17, 0); ts_b = ref_ts_exp;
        finish_burst();
        chk("b2b.nword", word_q.size(), 2);
        chk("b2b.word0", word_q[0], 17'h0E5E9);
        chk("b2b.word1", word_q[1], 17'h0F1C8);
        chk("b2b.ts0",   wts_q[0], ts_a);
        chk("b2b.ts1",   wts_q[1], ts_b);
        chk("b2b.nerr",  err_q.size(), 0);

        // Random bursts, 17..20 bits, jittered
        for (int r = 0; r < 4; r++) begin
            int n;
            n = 17 + int'($urandom_range(3));
            cur.delete();
            for (int i = 0; i < n; i++) cur.push_back(bit'($urandom_range(1)));
            start(); send_burst(n, 1); finish_burst();
            check_clean($sformatf("rand%0d", r), n);
        end

        // Reset in the middle of a burst
        start(); send_burst(8, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst.out", {bit_valid, word_valid, err, err_code, word, word_ts}, 64'd0);
        envelop_wire = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        clr();
        gap(8); gap(8); gap(16); gap(8);
        tick(40);
        chk("midrst.quiet", bit_q.size() + word_q.size() + err_q.size(), 0);
        chk("midrst.word", {word, word_ts, err_code}, 64'd0);

        load_str("01111000111001000");
        start(); send_burst(17, 0); finish_burst();
        check_clean("post_rst", 17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
